// File: rtl/matrix_keypad_scan_pkg.sv
// Shared definitions for the 16x16 key matrix scanner: geometry, register
// selects and the row-word type matching the matrix framebuffer layout.
package matrix_kbd_pkg;

    localparam int COLS = 16;
    localparam int ROWS = 16;

    localparam logic [1:0] REG_STATE  = 2'b00;
    localparam logic [1:0] REG_EVENT  = 2'b01;
    localparam logic [1:0] REG_STATUS = 2'b10;
    localparam logic [1:0] REG_CTRL   = 2'b11;

    typedef logic [15:0] row_word_t;

    // Column c lands in bit 15-c so a row word reads left-to-right like the display.
    function automatic logic [3:0] col_to_bit(input logic [3:0] col);
        return 4'd15 - col;
    endfunction

endpackage

// File: rtl/matrix_keypad_scan_if.sv
// CPU-side register bus of the key matrix scanner: word address, write data,
// strobes and registered read data.
interface matrix_keypad_scan_if;

    logic [29:0] address;
    logic [31:0] data_in;
    logic        we;
    logic        re;
    logic [31:0] data_out;

    modport master (
        output address,
        output data_in,
        output we,
        output re,
        input  data_out
    );

    modport slave (
        input  address,
        input  data_in,
        input  we,
        input  re,
        output data_out
    );

endinterface

// File: rtl/matrix_keypad_scan_col_debounce.sv
// Debounce history for one matrix column: last raw sample plus a saturating
// run-length counter; flags a commit when the run reaches DEBOUNCE samples.
module col_debounce
    import matrix_kbd_pkg::*;
#(
    parameter int DEBOUNCE = 4
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      sample_en,
    input  row_word_t sample,
    output logic      commit
);

    row_word_t  raw;
    logic [3:0] cnt;
    logic [3:0] cnt_nxt;

    always_comb begin
        cnt_nxt = cnt;
        if (sample != raw) begin
            cnt_nxt = '0;
        end else if (cnt != 4'hF) begin
            cnt_nxt = cnt + 4'd1;
        end
    end

    // With a single-sample threshold the counter runs past 0 on stable input,
    // so every enabled sample commits instead of relying on the count match.
    always_comb begin
        commit = sample_en && ((DEBOUNCE == 1) || (cnt_nxt == 4'(DEBOUNCE - 1)));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            raw <= '0;
            cnt <= '0;
        end else if (sample_en) begin
            raw <= sample;
            cnt <= cnt_nxt;
        end
    end

endmodule

// File: rtl/matrix_keypad_scan.sv
// Memory-mapped 16x16 key matrix scanner: column drive, row synchronizer,
// per-column debounce, key state / sticky press events and interrupt.
module matrix_keypad_scan
    import matrix_kbd_pkg::*;
#(
    parameter int SCAN_DIV = 16,
    parameter int DEBOUNCE = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    matrix_keypad_scan_if.slave  bus,
    input  logic [15:0]          from_matrix,
    output logic [3:0]           matrix_col_sel,
    output logic                 irq
);

    localparam int              DW         = $clog2(SCAN_DIV);
    localparam logic [DW-1:0]   DWELL_LAST = DW'(SCAN_DIV - 1);

    logic [DW-1:0] dwell;
    row_word_t     sync_q1;
    row_word_t     sync_q2;
    logic [15:0]   frame_cnt;
    logic          sample_en;
    logic [COLS-1:0] col_en;
    logic [COLS-1:0] commit;
    logic          commit_any;
    logic [3:0]    commit_bit;

    row_word_t     key_state     [ROWS];
    row_word_t     key_state_nxt [ROWS];
    row_word_t     key_event     [ROWS];
    row_word_t     key_event_nxt [ROWS];

    logic          ien;
    logic          any_event;
    logic [1:0]    reg_sel;
    logic [2:0]    pair;
    logic [3:0]    row_hi;
    logic [3:0]    row_lo;
    logic          evt_clr;
    logic [31:0]   rd_data;
    logic          unused_bus;

    assign unused_bus = ^{bus.address[29:5], bus.data_in[31:1]};

    // ---------------------------------------------------------------- scan
    assign sample_en = (dwell == DWELL_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q1        <= '0;
            sync_q2        <= '0;
            dwell          <= '0;
            matrix_col_sel <= '0;
            frame_cnt      <= '0;
        end else begin
            sync_q1 <= from_matrix;
            sync_q2 <= sync_q1;
            if (sample_en) begin
                dwell          <= '0;
                matrix_col_sel <= matrix_col_sel + 4'd1;
                if (matrix_col_sel == 4'd15) begin
                    frame_cnt <= frame_cnt + 16'd1;
                end
            end else begin
                dwell <= dwell + DW'(1);
            end
        end
    end

    // ------------------------------------------------------------ debounce
    always_comb begin
        col_en = '0;
        for (int unsigned c = 0; c < COLS; c++) begin
            col_en[c] = sample_en && (matrix_col_sel == 4'(c));
        end
    end

    for (genvar c = 0; c < COLS; c++) begin : g_col
        col_debounce #(
            .DEBOUNCE (DEBOUNCE)
        ) u_col_debounce (
            .clk       (clk),
            .rst_n     (rst_n),
            .sample_en (col_en[c]),
            .sample    (sync_q2),
            .commit    (commit[c])
        );
    end

    assign commit_any = |commit;
    assign commit_bit = col_to_bit(matrix_col_sel);

    // ------------------------------------------------------- bus decode
    assign reg_sel = bus.address[4:3];
    assign pair    = bus.address[2:0];
    assign row_hi  = {pair, 1'b0};
    assign row_lo  = {pair, 1'b1};
    assign evt_clr = bus.re && (reg_sel == REG_EVENT);

    // Read-clear is applied before the commit so a press landing in the same
    // cycle survives; the read itself still returns the pre-update value.
    always_comb begin
        key_state_nxt = key_state;
        key_event_nxt = key_event;
        if (evt_clr) begin
            key_event_nxt[row_hi] = '0;
            key_event_nxt[row_lo] = '0;
        end
        if (commit_any) begin
            for (int unsigned r = 0; r < ROWS; r++) begin
                if (sync_q2[r] && !key_state[r][commit_bit]) begin
                    key_event_nxt[r][commit_bit] = 1'b1;
                end
                key_state_nxt[r][commit_bit] = sync_q2[r];
            end
        end
    end

    always_comb begin
        any_event = 1'b0;
        for (int unsigned r = 0; r < ROWS; r++) begin
            any_event = any_event | (|key_event[r]);
        end
    end

    always_comb begin
        rd_data = '0;
        case (reg_sel)
            REG_STATE:  rd_data = {key_state[row_hi], key_state[row_lo]};
            REG_EVENT:  rd_data = {key_event[row_hi], key_event[row_lo]};
            REG_STATUS: rd_data = {frame_cnt, 8'h00, matrix_col_sel, 2'b00, ien, any_event};
            REG_CTRL:   rd_data = {31'b0, ien};
            default:    rd_data = '0;
        endcase
    end

    // ---------------------------------------------------------- registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned r = 0; r < ROWS; r++) begin
                key_state[r] <= '0;
                key_event[r] <= '0;
            end
            ien          <= 1'b0;
            bus.data_out <= '0;
            irq          <= 1'b0;
        end else begin
            key_state <= key_state_nxt;
            key_event <= key_event_nxt;
            if (bus.we && (reg_sel == REG_CTRL)) begin
                ien <= bus.data_in[0];
            end
            if (bus.re) begin
                bus.data_out <= rd_data;
            end
            irq <= ien & any_event;
        end
    end

endmodule

// File: tb/tb_matrix_keypad_scan.sv
// Directed bench for matrix_keypad_scan: a DEBOUNCE=4 instance and a
// DEBOUNCE=1 instance, each driven by a simple key-matrix model.
module tb_matrix_keypad_scan;

    logic        clk;
    logic        rst_n;
    logic [15:0] fm0;
    logic [15:0] fm1;
    logic [3:0]  col0;
    logic [3:0]  col1;
    logic        irq0;
    logic        irq1;

    logic [15:0] keys0 [16];
    logic [15:0] keys1 [16];

    int unsigned cyc;
    int          n_checks;
    int          n_errors;

    matrix_keypad_scan_if bus0 ();
    matrix_keypad_scan_if bus1 ();

    matrix_keypad_scan #(
        .SCAN_DIV (16),
        .DEBOUNCE (4)
    ) u_dut0 (
        .clk            (clk),
        .rst_n          (rst_n),
        .bus            (bus0),
        .from_matrix    (fm0),
        .matrix_col_sel (col0),
        .irq            (irq0)
    );

    matrix_keypad_scan #(
        .SCAN_DIV (16),
        .DEBOUNCE (1)
    ) u_dut1 (
        .clk            (clk),
        .rst_n          (rst_n),
        .bus            (bus1),
        .from_matrix    (fm1),
        .matrix_col_sel (col1),
        .irq            (irq1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    // Row r senses the key at (r, currently driven column).
    always_comb begin
        for (int r = 0; r < 16; r++) begin
            fm0[r] = keys0[r][col0];
            fm1[r] = keys1[r][col1];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic rd(input int which, input logic [4:0] a, output logic [31:0] d);
        if (which == 0) begin
            bus0.address = {25'b0, a};
            bus0.re      = 1'b1;
        end else begin
            bus1.address = {25'b0, a};
            bus1.re      = 1'b1;
        end
        @(negedge clk);
        bus0.re = 1'b0;
        bus1.re = 1'b0;
        d = (which == 0) ? bus0.data_out : bus1.data_out;
    endtask

    task automatic rd_chk(input int which, input string tag, input logic [4:0] a, input logic [31:0] exp);
        logic [31:0] d;
        rd(which, a, d);
        check(tag, d, exp);
    endtask

    task automatic wr(input int which, input logic [4:0] a, input logic [31:0] v);
        if (which == 0) begin
            bus0.address = {25'b0, a};
            bus0.data_in = v;
            bus0.we      = 1'b1;
        end else begin
            bus1.address = {25'b0, a};
            bus1.data_in = v;
            bus1.we      = 1'b1;
        end
        @(negedge clk);
        bus0.we = 1'b0;
        bus1.we = 1'b0;
    endtask

    function automatic logic [31:0] status_exp(input int unsigned n, input logic ie, input logic any);
        return {16'(n / 256), 8'h00, 4'((n / 16) % 16), 2'b00, ie, any};
    endfunction

    task automatic rd_status(input string tag, input logic ie, input logic any);
        int unsigned n;
        logic [31:0] d;
        n = cyc;
        rd(0, 5'h10, d);
        check(tag, d, status_exp(n, ie, any));
    endtask

    task automatic wait_col(input logic [3:0] target);
        int unsigned n;
        n = 0;
        while (col0 != target && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (col0 != target) check("wait_col_timeout", {28'b0, col0}, {28'b0, target});
    endtask

    // Returns just after column c has been sampled once more (call from column c+1).
    task automatic next_sample(input logic [3:0] c);
        wait_col(c + 4'd2);
        wait_col(c + 4'd1);
    endtask

    task automatic wait_irq0(input int unsigned budget);
        int unsigned n;
        n = 0;
        while (irq0 !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("irq_rise", {31'b0, irq0}, 32'h1);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        for (int r = 0; r < 16; r++) begin
            keys0[r] = '0;
            keys1[r] = '0;
        end
        bus0.address = '0; bus0.data_in = '0; bus0.we = 1'b0; bus0.re = 1'b0;
        bus1.address = '0; bus1.data_in = '0; bus1.we = 1'b0; bus1.re = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // 1: reset state and idle scan
        check("rst_col", {28'b0, col0}, 32'h0);
        check("rst_irq", {31'b0, irq0}, 32'h0);
        check("rst_dout", bus0.data_out, 32'h0);
        for (int i = 1; i <= 16; i++) begin
            repeat (16) @(negedge clk);
            check($sformatf("col_step%0d", i), {28'b0, col0}, 32'(i % 16));
        end
        for (int k = 0; k < 8; k++) begin
            rd_chk(0, $sformatf("idle_state%0d", k), 5'(k), 32'h0);
            rd_chk(0, $sformatf("idle_event%0d", k), 5'(8 + k), 32'h0);
        end
        rd_chk(0, "idle_ctrl", 5'h18, 32'h0);
        rd_status("idle_status", 1'b0, 1'b0);
        check("idle_irq", {31'b0, irq0}, 32'h0);

        // 2: press row 3 / col 5 with interrupt enabled
        wr(0, 5'h18, 32'h1);
        rd_chk(0, "ctrl_ien", 5'h18, 32'h1);
        keys0[3][5] = 1'b1;
        wait_irq0(2000);
        rd_chk(0, "press_state", 5'h01, 32'h0000_0400);
        rd_status("press_status", 1'b1, 1'b1);
        rd_chk(0, "press_event", 5'h09, 32'h0000_0400);
        check("irq_lag_hold", {31'b0, irq0}, 32'h1);
        rd_chk(0, "event_cleared", 5'h09, 32'h0);
        check("irq_fall", {31'b0, irq0}, 32'h0);

        // 3: bounce row 0 / col 0, then settle high
        wait_col(4'd1);
        keys0[0][0] = 1'b1;
        next_sample(4'd0);
        keys0[0][0] = 1'b0;
        next_sample(4'd0);
        keys0[0][0] = 1'b1;
        next_sample(4'd0);
        next_sample(4'd0);
        next_sample(4'd0);
        rd_chk(0, "bounce_nocommit", 5'h00, 32'h0);
        check("bounce_irq", {31'b0, irq0}, 32'h0);
        next_sample(4'd0);
        rd_chk(0, "settle_state", 5'h00, 32'h8000_0000);
        rd_chk(0, "settle_event", 5'h08, 32'h8000_0000);

        // 4: release row 3 / col 5
        wait_col(4'd6);
        keys0[3][5] = 1'b0;
        next_sample(4'd5);
        next_sample(4'd5);
        next_sample(4'd5);
        rd_chk(0, "release_pending", 5'h01, 32'h0000_0400);
        next_sample(4'd5);
        rd_chk(0, "release_state", 5'h01, 32'h0);
        rd_chk(0, "release_event", 5'h09, 32'h0);
        check("release_irq", {31'b0, irq0}, 32'h0);

        // 4b: DEBOUNCE=1, row 7 / col 12 pressed and released in alternate frames
        wr(1, 5'h18, 32'h1);
        wait_col(4'd13);
        keys1[7][12] = 1'b1;
        next_sample(4'd12);
        check("d1_irq_lag", {31'b0, irq1}, 32'h0);
        @(negedge clk);
        check("d1_irq_rise", {31'b0, irq1}, 32'h1);
        rd_chk(1, "d1_press_state", 5'h03, 32'h0000_0008);
        rd_chk(1, "d1_press_event", 5'h0B, 32'h0000_0008);
        keys1[7][12] = 1'b0;
        next_sample(4'd12);
        rd_chk(1, "d1_release_state", 5'h03, 32'h0);
        rd_chk(1, "d1_release_event", 5'h0B, 32'h0);
        keys1[7][12] = 1'b1;
        next_sample(4'd12);
        rd_chk(1, "d1_repress_event", 5'h0B, 32'h0000_0008);

        // 5: read-clear in the same cycle as a new press commit
        keys1[7][12] = 1'b0;
        next_sample(4'd12);
        rd_chk(1, "d1_idle_state", 5'h03, 32'h0);
        keys1[7][12] = 1'b1;
        wait_col(4'd12);
        repeat (15) @(negedge clk);
        rd_chk(1, "race_read", 5'h0B, 32'h0);
        rd_chk(1, "race_after", 5'h0B, 32'h0000_0008);
        rd_chk(1, "race_state", 5'h03, 32'h0000_0008);

        // 6: one-cycle reset mid-frame
        keys1[7][12] = 1'b0;
        wait_col(4'd9);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("mid_rst_col0", {28'b0, col0}, 32'h0);
        check("mid_rst_col1", {28'b0, col1}, 32'h0);
        check("mid_rst_irq0", {31'b0, irq0}, 32'h0);
        check("mid_rst_irq1", {31'b0, irq1}, 32'h0);
        check("mid_rst_dout", bus0.data_out, 32'h0);
        rd_chk(0, "mid_rst_state", 5'h00, 32'h0);
        rd_chk(0, "mid_rst_ctrl", 5'h18, 32'h0);
        rd_status("mid_rst_status", 1'b0, 1'b0);
        wait_col(4'd1);
        check("resume_cycle", cyc, 32'd16);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
